// File: rtl/ifft8_pkg.sv
// Shared definitions for the 8-point IFFT butterfly scheduler: sizes, FSM
// states, the bit-reversal used on load and the in-place DIT addressing.
package ifft8_pkg;

  localparam int N     = 8;
  localparam int LOG2N = 3;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    UNLOAD = 2'd3
  } state_t;

  // 3-bit index reversal: natural input order -> bit-reversed buffer slot.
  function automatic logic [LOG2N-1:0] rev3(input logic [LOG2N-1:0] n);
    return {n[0], n[1], n[2]};
  endfunction

  // Top operand of pair k in stage s: group base (k>>s)*2h plus offset j.
  function automatic logic [2:0] a_idx(input logic [1:0] s, input logic [1:0] k);
    logic [2:0] kk;
    logic [2:0] h;
    logic [2:0] j;
    kk = {1'b0, k};
    h  = 3'd1 << s;
    j  = kk & (h - 3'd1);
    return ((kk >> s) << (s + 2'd1)) | j;
  endfunction

  // Bottom operand sits one span above the top operand.
  function automatic logic [2:0] b_idx(input logic [1:0] s, input logic [1:0] k);
    return a_idx(s, k) + (3'd1 << s);
  endfunction

  // Twiddle exponent: offset within the group scaled to the W8 grid.
  function automatic logic [1:0] tw_idx(input logic [1:0] s, input logic [1:0] k);
    logic [2:0] kk;
    logic [2:0] h;
    logic [2:0] j;
    logic [2:0] t;
    kk = {1'b0, k};
    h  = 3'd1 << s;
    j  = kk & (h - 3'd1);
    t  = j << (2'd2 - s);
    return t[1:0];
  endfunction

endpackage

// File: rtl/ifft8_addr_gen.sv
// Combinational operand/twiddle address generator for one butterfly issue.
module ifft8_addr_gen
  import ifft8_pkg::*;
(
  input  logic [1:0] s,
  input  logic [1:0] k,
  output logic [2:0] a,
  output logic [2:0] b,
  output logic [1:0] tw
);

  assign a  = a_idx(s, k);
  assign b  = b_idx(s, k);
  assign tw = tw_idx(s, k);

endmodule

// File: rtl/ifft8_bfly_sched.sv
// Time-shares one external registered radix-2 butterfly across the three
// stages of an 8-point IFFT: bit-reversed load, 12 in-place butterflies with
// a bubble after stages 0 and 1, then a natural-order unload.
module ifft8_bfly_sched
  import ifft8_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_re,
  input  logic [DATA_W-1:0] in_im,
  output logic              bf_en,
  output logic [DATA_W-1:0] bf_a_re,
  output logic [DATA_W-1:0] bf_a_im,
  output logic [DATA_W-1:0] bf_b_re,
  output logic [DATA_W-1:0] bf_b_im,
  output logic [1:0]        bf_tw,
  input  logic [DATA_W-1:0] bf_y0_re,
  input  logic [DATA_W-1:0] bf_y0_im,
  input  logic [DATA_W-1:0] bf_y1_re,
  input  logic [DATA_W-1:0] bf_y1_im,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_re,
  output logic [DATA_W-1:0] out_im,
  output logic              out_last,
  output logic              busy
);

  state_t           state_reg;
  logic [1:0]       s_reg;
  logic [1:0]       k_reg;
  logic             bubble_reg;
  logic [LOG2N-1:0] cnt_reg;

  logic             wb_en_reg;
  logic [2:0]       wb_a_reg;
  logic [2:0]       wb_b_reg;

  logic [DATA_W-1:0] work_re [N];
  logic [DATA_W-1:0] work_im [N];

  logic [2:0]       a_sel;
  logic [2:0]       b_sel;
  logic [1:0]       tw_sel;
  logic [LOG2N-1:0] load_slot;
  logic             load_acc;
  logic             unload_hs;

  ifft8_addr_gen u_addr (
    .s  (s_reg),
    .k  (k_reg),
    .a  (a_sel),
    .b  (b_sel),
    .tw (tw_sel)
  );

  // cnt_reg counts samples in LOAD and doubles as the read index in UNLOAD.
  assign load_slot = rev3(cnt_reg);
  assign load_acc  = in_valid && in_ready;
  assign unload_hs = out_valid && out_ready;

  // in_ready is masked by reset so that every output reads 0 while it is held.
  assign in_ready  = (state_reg == LOAD) && !reset;
  assign busy      = (state_reg != LOAD);
  assign bf_en     = (state_reg == ISSUE) && !bubble_reg;
  assign out_valid = (state_reg == UNLOAD);
  assign out_last  = out_valid && (cnt_reg == 3'd7);

  // Operand and output buses are forced to 0 when not qualified so that they
  // are quiet during reset and outside their phase.
  assign bf_a_re = bf_en ? work_re[a_sel] : '0;
  assign bf_a_im = bf_en ? work_im[a_sel] : '0;
  assign bf_b_re = bf_en ? work_re[b_sel] : '0;
  assign bf_b_im = bf_en ? work_im[b_sel] : '0;
  assign bf_tw   = bf_en ? tw_sel : 2'd0;
  assign out_re  = out_valid ? work_re[cnt_reg] : '0;
  assign out_im  = out_valid ? work_im[cnt_reg] : '0;

  // Working buffer: each entry takes a loaded sample or a butterfly result.
  // Loads and write-backs never overlap in time, so the priority is moot.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_work
      // Per-entry write port; contents are intentionally not reset.
      always_ff @(posedge clk) begin
        if (load_acc && (load_slot == 3'(gi))) begin
          work_re[gi] <= in_re;
          work_im[gi] <= in_im;
        end else if (wb_en_reg && (wb_a_reg == 3'(gi))) begin
          work_re[gi] <= bf_y0_re;
          work_im[gi] <= bf_y0_im;
        end else if (wb_en_reg && (wb_b_reg == 3'(gi))) begin
          work_re[gi] <= bf_y1_re;
          work_im[gi] <= bf_y1_im;
        end
      end
    end
  endgenerate

  // Delay the issue strobe and addresses to line up with the butterfly output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_en_reg <= 1'b0;
      wb_a_reg  <= 3'd0;
      wb_b_reg  <= 3'd0;
    end else begin
      wb_en_reg <= bf_en;
      wb_a_reg  <= a_sel;
      wb_b_reg  <= b_sel;
    end
  end

  // Frame sequencer: LOAD -> ISSUE (12 pairs, 2 bubbles) -> DRAIN -> UNLOAD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= LOAD;
      cnt_reg    <= '0;
      s_reg      <= 2'd0;
      k_reg      <= 2'd0;
      bubble_reg <= 1'b0;
    end else begin
      case (state_reg)
        LOAD: begin
          if (load_acc) begin
            cnt_reg <= cnt_reg + 3'd1;
            if (cnt_reg == 3'd7) begin
              state_reg  <= ISSUE;
              s_reg      <= 2'd0;
              k_reg      <= 2'd0;
              bubble_reg <= 1'b0;
            end
          end
        end
        ISSUE: begin
          if (bubble_reg) begin
            // Bubble lets the last result of the previous stage land first.
            bubble_reg <= 1'b0;
          end else if (k_reg == 2'd3) begin
            k_reg <= 2'd0;
            if (s_reg == 2'd2) begin
              state_reg <= DRAIN;
            end else begin
              s_reg      <= s_reg + 2'd1;
              bubble_reg <= 1'b1;
            end
          end else begin
            k_reg <= k_reg + 2'd1;
          end
        end
        DRAIN: begin
          state_reg <= UNLOAD;
          cnt_reg   <= '0;
        end
        UNLOAD: begin
          if (unload_hs) begin
            cnt_reg <= cnt_reg + 3'd1;
            if (cnt_reg == 3'd7) begin
              state_reg <= LOAD;
            end
          end
        end
        default: state_reg <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_ifft8_bfly_sched.sv
// Self-checking bench for ifft8_bfly_sched with a behavioural butterfly and
// a textbook in-place radix-2 reference model.
module tb_ifft8_bfly_sched;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic signed [W-1:0] in_re, in_im;
  logic          bf_en;
  logic signed [W-1:0] bf_a_re, bf_a_im, bf_b_re, bf_b_im;
  logic [1:0]    bf_tw;
  logic signed [W-1:0] bf_y0_re = '0, bf_y0_im = '0, bf_y1_re = '0, bf_y1_im = '0;
  logic          out_valid;
  logic          out_ready;
  logic signed [W-1:0] out_re, out_im;
  logic          out_last;
  logic          busy;

  ifft8_bfly_sched #(.DATA_W(W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
    .bf_en(bf_en), .bf_a_re(bf_a_re), .bf_a_im(bf_a_im),
    .bf_b_re(bf_b_re), .bf_b_im(bf_b_im), .bf_tw(bf_tw),
    .bf_y0_re(bf_y0_re), .bf_y0_im(bf_y0_im), .bf_y1_re(bf_y1_re), .bf_y1_im(bf_y1_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; int ar; int ai; int br; int bi; int tw;} iss_t;
  typedef struct {int s; int k; int a; int b; int tw;} addr_vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int bf_mode = 0;
  int acc_cnt = 0;
  int c0 = -1;
  int first_ov = -1;
  iss_t iss_q[$];
  iss_t exp_iss[12];
  int x_re[8], x_im[8];
  int exp_re[8], exp_im[8];
  int got_re[8], got_im[8], got_last[8];
  int got_n;
  addr_vec_t tbl[12];

  logic pend = 1'b0;
  int m0r, m0i, m1r, m1i;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int t16(input int v);
    logic signed [15:0] x;
    x = v[15:0];
    return int'(x);
  endfunction

  function automatic int rev(input int n);
    return ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
  endfunction

  // Butterfly flavours: 0 pass-through, 1 ideal (W8 = e^{+j pi/4}), 2 scrambling.
  function automatic void bfly(input int mode, input int ar, input int ai, input int br,
                               input int bi, input int tw, output int y0r, output int y0i,
                               output int y1r, output int y1i);
    int wr, wi;
    wr = br; wi = bi;
    y0r = ar; y0i = ai; y1r = br; y1i = bi;
    if (mode == 1) begin
      case (tw)
        0: begin wr = br; wi = bi; end
        1: begin wr = ((br - bi) * 181) >>> 8; wi = ((br + bi) * 181) >>> 8; end
        2: begin wr = -bi; wi = br; end
        default: begin wr = ((-br - bi) * 181) >>> 8; wi = ((br - bi) * 181) >>> 8; end
      endcase
      y0r = ar + wr; y0i = ai + wi; y1r = ar - wr; y1i = ai - wi;
    end else if (mode == 2) begin
      y0r = ar + br + 3 * tw + 1;
      y0i = ai - bi;
      y1r = ar - 2 * br;
      y1i = bi ^ (ai + 5 * tw);
    end
    y0r = t16(y0r); y0i = t16(y0i); y1r = t16(y1r); y1i = t16(y1i);
  endfunction

  // Observe accepts, issues and first out_valid; compute the butterfly result.
  always @(negedge clk) begin
    pend = 1'b0;
    if (!reset) begin
      if (in_valid && in_ready) begin
        acc_cnt++;
        if (acc_cnt == 8) c0 = cyc + 1;
      end
      if (bf_en) begin
        bfly(bf_mode, int'(bf_a_re), int'(bf_a_im), int'(bf_b_re), int'(bf_b_im),
             int'(bf_tw), m0r, m0i, m1r, m1i);
        pend = 1'b1;
        iss_q.push_back('{cyc, int'(bf_a_re), int'(bf_a_im), int'(bf_b_re),
                          int'(bf_b_im), int'(bf_tw)});
      end
      if (out_valid && first_ov < 0) first_ov = cyc;
    end
  end

  // Registered butterfly: captures operands on the issue edge.
  always @(posedge clk) begin
    if (pend) begin
      bf_y0_re <= m0r[W-1:0]; bf_y0_im <= m0i[W-1:0];
      bf_y1_re <= m1r[W-1:0]; bf_y1_im <= m1i[W-1:0];
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string name);
    int nz;
    nz = int'(in_ready | bf_en | (bf_tw != 0) | out_valid | out_last | busy |
              (bf_a_re != 0) | (bf_a_im != 0) | (bf_b_re != 0) | (bf_b_im != 0) |
              (out_re != 0) | (out_im != 0));
    chk(name, nz, 0);
  endtask

  // Reference: bit-reversed load, then the textbook group/offset DIT loops.
  task automatic model_frame(input int mode);
    int m_re[8], m_im[8];
    int idx, h, a, b, tw, y0r, y0i, y1r, y1i;
    for (int n = 0; n < 8; n++) begin
      m_re[rev(n)] = x_re[n];
      m_im[rev(n)] = x_im[n];
    end
    idx = 0;
    for (int s = 0; s < 3; s++) begin
      h = 1 << s;
      for (int g = 0; g < 8; g += 2 * h) begin
        for (int j = 0; j < h; j++) begin
          a = g + j; b = a + h; tw = j * (4 / h);
          exp_iss[idx] = '{5 * s + (idx % 4), m_re[a], m_im[a], m_re[b], m_im[b], tw};
          bfly(mode, m_re[a], m_im[a], m_re[b], m_im[b], tw, y0r, y0i, y1r, y1i);
          m_re[a] = y0r; m_im[a] = y0i; m_re[b] = y1r; m_im[b] = y1i;
          idx++;
        end
      end
    end
    for (int i = 0; i < 8; i++) begin
      exp_re[i] = m_re[i];
      exp_im[i] = m_im[i];
    end
  endtask

  task automatic send_frame(input bit gap);
    int t;
    for (int n = 0; n < 8; n++) begin
      if (gap && n == 3) begin
        in_valid = 1'b0;
        repeat (3) step();
      end
      in_valid = 1'b1;
      in_re = x_re[n][W-1:0];
      in_im = x_im[n][W-1:0];
      t = 0;
      while (!in_ready && t < 100) begin step(); t++; end
      if (!in_ready) begin
        errors++; checks++;
        $display("FAIL send_timeout: in_ready stuck low at sample %0d", n);
      end
      step();
    end
    in_valid = 1'b0;
  endtask

  // Drain one frame; optional 1010 backpressure with junk on the input port.
  task automatic collect(input bit toggle);
    int t;
    bit hold, seen;
    int h_re, h_im, h_last;
    got_n = 0; t = 0; hold = 0; seen = 0;
    h_re = 0; h_im = 0; h_last = 0;
    while (got_n < 8 && t < 400) begin
      out_ready = toggle ? (t % 2 == 0) : 1'b1;
      if (toggle) begin
        in_valid = 1'b1; in_re = 16'sh5a5a; in_im = -16'sd77;
      end
      if (hold) begin
        chk("stall_valid", int'(out_valid), 1);
        chk("stall_re", int'(out_re), h_re);
        chk("stall_im", int'(out_im), h_im);
        chk("stall_last", int'(out_last), h_last);
        hold = 0;
      end
      if (out_valid) begin
        if (!seen) begin chk("in_ready_unload", int'(in_ready), 0); seen = 1; end
        if (out_ready) begin
          got_re[got_n] = int'(out_re);
          got_im[got_n] = int'(out_im);
          got_last[got_n] = int'(out_last);
          got_n++;
          if (got_n == 8) in_valid = 1'b0;
        end else begin
          hold = 1; h_re = int'(out_re); h_im = int'(out_im); h_last = int'(out_last);
        end
      end
      step();
      t++;
    end
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("out_count", got_n, 8);
    chk("in_ready_after_last", int'(in_ready), 1);
    chk("busy_after_last", int'(busy), 0);
  endtask

  task automatic run_frame(input int mode, input bit gap, input bit toggle, input string tag);
    bf_mode = mode;
    iss_q.delete();
    acc_cnt = 0; c0 = -1; first_ov = -1;
    model_frame(mode);
    send_frame(gap);
    collect(toggle);
    chk({tag, "_first_out_valid"}, first_ov - c0, 15);
    chk({tag, "_issue_count"}, iss_q.size(), 12);
    for (int i = 0; i < 12 && i < iss_q.size(); i++) begin
      chk({tag, "_iss_cyc"}, iss_q[i].cyc - c0, exp_iss[i].cyc);
      chk({tag, "_iss_a_re"}, iss_q[i].ar, exp_iss[i].ar);
      chk({tag, "_iss_a_im"}, iss_q[i].ai, exp_iss[i].ai);
      chk({tag, "_iss_b_re"}, iss_q[i].br, exp_iss[i].br);
      chk({tag, "_iss_b_im"}, iss_q[i].bi, exp_iss[i].bi);
      chk({tag, "_iss_tw"}, iss_q[i].tw, exp_iss[i].tw);
    end
    for (int i = 0; i < got_n; i++) begin
      chk({tag, "_out_re"}, got_re[i], exp_re[i]);
      chk({tag, "_out_im"}, got_im[i], exp_im[i]);
      chk({tag, "_out_last"}, got_last[i], (i == 7) ? 1 : 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    tbl = '{'{0,0,0,1,0}, '{0,1,2,3,0}, '{0,2,4,5,0}, '{0,3,6,7,0},
            '{1,0,0,2,0}, '{1,1,1,3,2}, '{1,2,4,6,0}, '{1,3,5,7,2},
            '{2,0,0,4,0}, '{2,1,1,5,1}, '{2,2,2,6,2}, '{2,3,3,7,3}};
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_re = '0; in_im = '0;
    step(); step();
    check_zero("reset_outputs");
    reset = 1'b0;
    #1;
    chk("post_reset_in_ready", int'(in_ready), 1);
    chk("post_reset_busy", int'(busy), 0);

    // Address sequence and bit-reversed load through a pass-through butterfly.
    for (int n = 0; n < 8; n++) begin x_re[n] = n; x_im[n] = -n; end
    run_frame(0, 1'b0, 1'b0, "passthru");
    for (int i = 0; i < 12 && i < iss_q.size(); i++) begin
      chk("tbl_cyc", iss_q[i].cyc - c0, 5 * tbl[i].s + tbl[i].k);
      chk("tbl_a", iss_q[i].ar, rev(tbl[i].a));
      chk("tbl_b", iss_q[i].br, rev(tbl[i].b));
      chk("tbl_tw", iss_q[i].tw, tbl[i].tw);
    end
    for (int i = 0; i < 8; i++) begin
      chk("bitrev_re", got_re[i], rev(i));
      chk("bitrev_im", got_im[i], -rev(i));
    end

    // Ideal butterfly: impulse and all-ones.
    for (int n = 0; n < 8; n++) begin x_re[n] = (n == 0) ? 1 : 0; x_im[n] = 0; end
    run_frame(1, 1'b0, 1'b0, "impulse");
    for (int i = 0; i < 8; i++) begin
      chk("impulse_re", got_re[i], 1);
      chk("impulse_im", got_im[i], 0);
    end
    for (int n = 0; n < 8; n++) begin x_re[n] = 1; x_im[n] = 0; end
    run_frame(1, 1'b0, 1'b0, "ones");
    for (int i = 0; i < 8; i++) begin
      chk("ones_re", got_re[i], (i == 0) ? 8 : 0);
      chk("ones_im", got_im[i], 0);
    end

    // Random frames: backpressure, input gaps, mixed butterflies.
    for (int f = 0; f < 4; f++) begin
      for (int n = 0; n < 8; n++) begin
        x_re[n] = t16(int'($urandom));
        x_im[n] = t16(int'($urandom));
      end
      run_frame((f % 2 == 0) ? 2 : 1, f == 1 || f == 3, f >= 2, "random");
    end

    // Reset at c6 of a frame, then a fresh frame.
    for (int n = 0; n < 8; n++) begin x_re[n] = n * 3 + 1; x_im[n] = 2 - n; end
    bf_mode = 2; acc_cnt = 0; c0 = -1;
    send_frame(1'b0);
    t = 0;
    while (cyc != c0 + 6 && t < 100) begin step(); t++; end
    chk("abort_reached_c6", cyc - c0, 6);
    chk("abort_busy_before", int'(busy), 1);
    reset = 1'b1;
    #1;
    check_zero("abort_reset_outputs");
    step();
    reset = 1'b0;
    #1;
    chk("abort_load_in_ready", int'(in_ready), 1);
    chk("abort_load_busy", int'(busy), 0);
    chk("abort_load_bf_en", int'(bf_en), 0);
    chk("abort_load_out_valid", int'(out_valid), 0);
    for (int n = 0; n < 8; n++) begin
      x_re[n] = t16(int'($urandom));
      x_im[n] = t16(int'($urandom));
    end
    run_frame(2, 1'b0, 1'b0, "after_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
